rr_arbiter_n: RTL

//   Parametrised N-requester arbiter; next generation of the 2-requester arbiter.

---
 rtl/rr_arbiter_n.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with registered one-hot grant: round-robin or fixed priority,
// a per-grant hold limit that forces rotation, and a lock that extends the current grant.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 lock,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int IDW = $clog2(N);
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [N-1:0]   ONE_HOT0  = N'(1);
    localparam logic [0:0]     S_IDLE    = 1'b0;
    localparam logic [0:0]     S_GRANT   = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_q, hold_d;

    logic           owner_req;
    logic           others_pend;
    logic           hold_limit;
    logic           keep;
    logic [N-1:0]   mask;
    logic           win_found;
    logic [IDW-1:0] win_id;

    always_comb begin
        owner_req   = (state_q == S_GRANT) && req[id_q];
        others_pend = |(req & ~gnt_q);
        hold_limit  = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);
        keep        = owner_req && (lock || !hold_limit || !others_pend);
        // Only reached with owner_req set on a hold-limit rotation: the owner sits out.
        mask        = owner_req ? (req & ~gnt_q) : req;
    end

    always_comb begin
        int             j;
        logic [IDW-1:0] jj;
        win_found = 1'b0;
        win_id    = '0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 0) begin
                j = int'(ptr_q) + k;
                if (j >= N) j = j - N;
            end else begin
                j = k;
            end
            jj = IDW'(j);
            if (!win_found && mask[jj]) begin
                win_found = 1'b1;
                win_id    = jj;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (keep) begin
            if (MAX_HOLD != 0 && hold_q < HOLD_LAST) hold_d = hold_q + 1'b1;
        end else if (win_found) begin
            state_d = S_GRANT;
            gnt_d   = ONE_HOT0 << win_id;
            id_d    = win_id;
            ptr_d   = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
            hold_d  = '0;
        end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;

endmodule
